// File: rtl/header_strip_pkg.sv
// Shared types and field layout for the header-stripping stage.
// Holds the FSM encoding, the status word layout and the saturating size adder.
package header_strip_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_BODY = 2'd1,
        ST_STAT = 2'd2
    } state_e;

    localparam int SIZE_W        = 16;
    localparam int COUNTED_LSB   = 16;
    localparam int DECLARED_LSB  = 0;
    localparam int FLAG_MISMATCH = 0;
    localparam int FLAG_RUNT     = 1;

    function automatic logic [SIZE_W-1:0] sat_add(input logic [SIZE_W-1:0] a,
                                                  input logic [SIZE_W-1:0] b);
        logic [SIZE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SIZE_W] ? {SIZE_W{1'b1}} : sum[SIZE_W-1:0];
    endfunction

endpackage

// File: rtl/header_stripping_module_keep_popcount.sv
// Combinational count of set bits in a tkeep vector.
module keep_popcount #(
    parameter  int KW = 16,
    localparam int CW = $clog2(KW) + 1
) (
    input  logic [KW-1:0] keep_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < KW; i++) begin
            count_o = count_o + CW'(keep_i[i]);
        end
    end

endmodule

// File: rtl/header_stripping_module.sv
// Strips the size header from each packet, forwards the body unchanged and
// reports declared vs. counted byte size plus error flags once per packet.
//
// state | meaning
// HDR   | waiting for header beat; header is consumed, never forwarded
// BODY  | combinational pass-through, counting tkeep bytes on each handshake
// STAT  | status word presented; input stalled until it is accepted
module header_stripping_module
    import header_strip_pkg::*;
#(
    parameter int DW = 128
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [DW-1:0]   s_axis_tdata,
    input  logic [DW/8-1:0] s_axis_tkeep,
    input  logic            s_axis_tlast,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    output logic [DW-1:0]   m_axis_pbody_tdata,
    output logic [DW/8-1:0] m_axis_pbody_tkeep,
    output logic            m_axis_pbody_tlast,
    output logic            m_axis_pbody_tvalid,
    input  logic            m_axis_pbody_tready,
    output logic [31:0]     m_axis_pstat_tdata,
    output logic [1:0]      m_axis_pstat_tuser,
    output logic            m_axis_pstat_tvalid,
    input  logic            m_axis_pstat_tready,
    output logic [31:0]     pkt_count,
    output logic [31:0]     err_count
);

    localparam int KW = DW / 8;
    localparam int CW = $clog2(KW) + 1;

    state_e            state_q;
    logic [SIZE_W-1:0] declared_q;
    logic [SIZE_W-1:0] counted_q;
    logic              runt_q;
    logic [31:0]       pstat_tdata_q;
    logic [1:0]        pstat_tuser_q;
    logic              pstat_tvalid_q;
    logic [31:0]       pkt_count_q;
    logic [31:0]       err_count_q;

    logic [CW-1:0]     beat_bytes;
    logic [SIZE_W-1:0] counted_d;
    logic              in_body;
    logic              s_hs;

    keep_popcount #(.KW(KW)) u_keep_popcount (
        .keep_i  (s_axis_tkeep),
        .count_o (beat_bytes)
    );

    assign counted_d = sat_add(counted_q, SIZE_W'(beat_bytes));
    assign in_body   = resetn && (state_q == ST_BODY);

    always_comb begin
        s_axis_tready = 1'b0;
        if (resetn) begin
            case (state_q)
                ST_HDR:  s_axis_tready = 1'b1;
                ST_BODY: s_axis_tready = m_axis_pbody_tready;
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    assign s_hs = s_axis_tvalid && s_axis_tready;

    assign m_axis_pbody_tvalid = in_body && s_axis_tvalid;
    assign m_axis_pbody_tdata  = in_body ? s_axis_tdata : '0;
    assign m_axis_pbody_tkeep  = in_body ? s_axis_tkeep : '0;
    assign m_axis_pbody_tlast  = in_body && s_axis_tlast;

    // Registered state is cleared only at the edge, so gate it while reset is held.
    assign m_axis_pstat_tdata  = resetn ? pstat_tdata_q : '0;
    assign m_axis_pstat_tuser  = resetn ? pstat_tuser_q : '0;
    assign m_axis_pstat_tvalid = resetn && pstat_tvalid_q;
    assign pkt_count           = resetn ? pkt_count_q : '0;
    assign err_count           = resetn ? err_count_q : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_HDR;
            declared_q     <= '0;
            counted_q      <= '0;
            runt_q         <= 1'b0;
            pstat_tdata_q  <= '0;
            pstat_tuser_q  <= '0;
            pstat_tvalid_q <= 1'b0;
            pkt_count_q    <= '0;
            err_count_q    <= '0;
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (s_hs) begin
                        declared_q <= s_axis_tdata[SIZE_W-1:0];
                        counted_q  <= '0;
                        if (s_axis_tlast) begin
                            runt_q <= 1'b1;
                            pstat_tdata_q[COUNTED_LSB +: SIZE_W]  <= '0;
                            pstat_tdata_q[DECLARED_LSB +: SIZE_W] <= s_axis_tdata[SIZE_W-1:0];
                            pstat_tuser_q[FLAG_MISMATCH] <= (s_axis_tdata[SIZE_W-1:0] != '0);
                            pstat_tuser_q[FLAG_RUNT]     <= 1'b1;
                            pstat_tvalid_q <= 1'b1;
                            state_q        <= ST_STAT;
                        end else begin
                            runt_q  <= 1'b0;
                            state_q <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (s_hs) begin
                        counted_q <= counted_d;
                        if (s_axis_tlast) begin
                            // Load status from the final sum so it includes the tlast beat.
                            pstat_tdata_q[COUNTED_LSB +: SIZE_W]  <= counted_d;
                            pstat_tdata_q[DECLARED_LSB +: SIZE_W] <= declared_q;
                            pstat_tuser_q[FLAG_MISMATCH] <= (counted_d != declared_q);
                            pstat_tuser_q[FLAG_RUNT]     <= runt_q;
                            pstat_tvalid_q <= 1'b1;
                            state_q        <= ST_STAT;
                        end
                    end
                end
                ST_STAT: begin
                    if (m_axis_pstat_tready) begin
                        pkt_count_q    <= pkt_count_q + 32'd1;
                        err_count_q    <= err_count_q + ((pstat_tuser_q != '0) ? 32'd1 : 32'd0);
                        pstat_tvalid_q <= 1'b0;
                        state_q        <= ST_HDR;
                    end
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_header_stripping_module.sv
// Directed bench for header_stripping_module with body/status scoreboards.
module tb_header_stripping_module;

    localparam int DW = 128;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } body_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  user;
    } stat_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_pbody_tdata;
    logic [KW-1:0] m_axis_pbody_tkeep;
    logic          m_axis_pbody_tlast;
    logic          m_axis_pbody_tvalid;
    logic          m_axis_pbody_tready = 1'b1;
    logic [31:0]   m_axis_pstat_tdata;
    logic [1:0]    m_axis_pstat_tuser;
    logic          m_axis_pstat_tvalid;
    logic          m_axis_pstat_tready = 1'b0;
    logic [31:0]   pkt_count;
    logic [31:0]   err_count;

    int checks = 0;
    int errors = 0;

    body_t body_q[$];
    stat_t stat_q[$];

    logic toggle_body = 1'b0;
    int   stat_hold = 0;
    int   hold_cnt = 0;

    logic        prev_held = 1'b0;
    logic [31:0] prev_tdata = '0;
    logic [1:0]  prev_tuser = '0;

    header_stripping_module #(.DW(DW)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .m_axis_pbody_tdata  (m_axis_pbody_tdata),
        .m_axis_pbody_tkeep  (m_axis_pbody_tkeep),
        .m_axis_pbody_tlast  (m_axis_pbody_tlast),
        .m_axis_pbody_tvalid (m_axis_pbody_tvalid),
        .m_axis_pbody_tready (m_axis_pbody_tready),
        .m_axis_pstat_tdata  (m_axis_pstat_tdata),
        .m_axis_pstat_tuser  (m_axis_pstat_tuser),
        .m_axis_pstat_tvalid (m_axis_pstat_tvalid),
        .m_axis_pstat_tready (m_axis_pstat_tready),
        .pkt_count           (pkt_count),
        .err_count           (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Body ready pattern and status-ready hold policy.
    initial forever begin
        @(posedge clk);
        #1;
        m_axis_pbody_tready = toggle_body ? ~m_axis_pbody_tready : 1'b1;
        if (m_axis_pstat_tvalid && !m_axis_pstat_tready) begin
            if (hold_cnt >= stat_hold) m_axis_pstat_tready = 1'b1;
            else hold_cnt++;
        end else begin
            m_axis_pstat_tready = 1'b0;
            hold_cnt = 0;
        end
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (m_axis_pbody_tvalid && m_axis_pbody_tready) begin
                chk("body_expected", DW'(body_q.size() != 0), DW'(1));
                if (body_q.size() != 0) begin
                    body_t e;
                    e = body_q.pop_front();
                    chk("body_tdata", m_axis_pbody_tdata, e.data);
                    chk("body_tkeep", DW'(m_axis_pbody_tkeep), DW'(e.keep));
                    chk("body_tlast", DW'(m_axis_pbody_tlast), DW'(e.last));
                end
            end
            if (m_axis_pstat_tvalid) begin
                chk("stat_stall_in", DW'(s_axis_tready), DW'(0));
                if (prev_held) begin
                    chk("stat_stable_tdata", DW'(m_axis_pstat_tdata), DW'(prev_tdata));
                    chk("stat_stable_tuser", DW'(m_axis_pstat_tuser), DW'(prev_tuser));
                end
            end
            if (m_axis_pstat_tvalid && m_axis_pstat_tready) begin
                chk("stat_expected", DW'(stat_q.size() != 0), DW'(1));
                if (stat_q.size() != 0) begin
                    stat_t e;
                    e = stat_q.pop_front();
                    chk("stat_tdata", DW'(m_axis_pstat_tdata), DW'(e.data));
                    chk("stat_tuser", DW'(m_axis_pstat_tuser), DW'(e.user));
                end
            end
            prev_held  = m_axis_pstat_tvalid && !m_axis_pstat_tready;
            prev_tdata = m_axis_pstat_tdata;
            prev_tuser = m_axis_pstat_tuser;
        end else begin
            prev_held = 1'b0;
        end
    end

    task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        logic hs;
        bit   done;
        done = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            if (hs) done = 1;
        end
        if (!done) chk("beat_timeout", DW'(done), DW'(1));
    endtask

    task automatic send_pkt(input logic [15:0] hdr, input int nbody, input logic [KW-1:0] last_keep);
        logic [DW-1:0] d;
        int counted;
        d = rand_data();
        d[15:0] = hdr;
        if (nbody == 0) begin
            stat_q.push_back('{data: {16'h0000, hdr}, user: {1'b1, hdr != 16'h0000}});
            beat(d, '1, 1'b1);
        end else begin
            beat(d, '1, 1'b0);
            counted = 0;
            for (int i = 1; i <= nbody; i++) begin
                body_t b;
                b.data = rand_data();
                b.keep = (i == nbody) ? last_keep : '1;
                b.last = (i == nbody);
                counted += $countones(b.keep);
                body_q.push_back(b);
                if (b.last)
                    stat_q.push_back('{data: {counted[15:0], hdr}, user: {1'b0, counted[15:0] != hdr}});
                beat(b.data, b.keep, b.last);
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (stat_q.size() == 0 && body_q.size() == 0) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk("drain_timeout", DW'(done), DW'(1));
    endtask

    initial begin
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
        chk("rst_body_tvalid", DW'(m_axis_pbody_tvalid), DW'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_s_tready", DW'(s_axis_tready), DW'(1));
        chk("idle_pstat_tvalid", DW'(m_axis_pstat_tvalid), DW'(0));
        chk("idle_pkt_count", DW'(pkt_count), DW'(0));
        chk("idle_err_count", DW'(err_count), DW'(0));
        @(posedge clk);
        #1;

        // Full packet; status must appear one cycle after the tlast handshake.
        stat_hold = 0;
        send_pkt(16'h0030, 3, '1);
        chk("stat_latency", DW'(m_axis_pstat_tvalid), DW'(1));
        drain();
        chk("p1_pkt_count", DW'(pkt_count), DW'(1));
        chk("p1_err_count", DW'(err_count), DW'(0));

        send_pkt(16'h0025, 3, 16'h001F);
        drain();
        chk("p2_pkt_count", DW'(pkt_count), DW'(2));

        send_pkt(16'h0040, 3, '1);
        drain();
        chk("p3_err_count", DW'(err_count), DW'(1));

        send_pkt(16'h0010, 0, '1);
        drain();
        chk("p4_err_count", DW'(err_count), DW'(2));

        send_pkt(16'h0000, 0, '1);
        drain();
        chk("p5_pkt_count", DW'(pkt_count), DW'(5));
        chk("p5_err_count", DW'(err_count), DW'(3));

        // Back-to-back with body backpressure and held status.
        toggle_body = 1'b1;
        stat_hold = 5;
        for (int p = 0; p < 4; p++) send_pkt(16'h0020, 2, '1);
        drain();
        chk("b2b_pkt_count", DW'(pkt_count), DW'(9));
        chk("b2b_err_count", DW'(err_count), DW'(3));
        toggle_body = 1'b0;
        stat_hold = 0;
        @(posedge clk);
        #1;

        // Reset during the second body beat abandons the packet.
        begin
            logic [DW-1:0] d;
            body_t b;
            d = rand_data();
            d[15:0] = 16'h0030;
            beat(d, '1, 1'b0);
            b.data = rand_data();
            b.keep = '1;
            b.last = 1'b0;
            body_q.push_back(b);
            beat(b.data, b.keep, b.last);
            s_axis_tdata  = rand_data();
            s_axis_tkeep  = '1;
            s_axis_tlast  = 1'b0;
            s_axis_tvalid = 1'b1;
            resetn = 1'b0;
            @(negedge clk);
            chk("mid_rst_s_tready", DW'(s_axis_tready), DW'(0));
            chk("mid_rst_body_tvalid", DW'(m_axis_pbody_tvalid), DW'(0));
            chk("mid_rst_body_tdata", m_axis_pbody_tdata, DW'(0));
            chk("mid_rst_body_tkeep", DW'(m_axis_pbody_tkeep), DW'(0));
            chk("mid_rst_body_tlast", DW'(m_axis_pbody_tlast), DW'(0));
            chk("mid_rst_pstat_tvalid", DW'(m_axis_pstat_tvalid), DW'(0));
            chk("mid_rst_pstat_tdata", DW'(m_axis_pstat_tdata), DW'(0));
            chk("mid_rst_pstat_tuser", DW'(m_axis_pstat_tuser), DW'(0));
            chk("mid_rst_pkt_count", DW'(pkt_count), DW'(0));
            chk("mid_rst_err_count", DW'(err_count), DW'(0));
            @(posedge clk);
            #1;
            resetn = 1'b1;
            chk("post_rst_pkt_count", DW'(pkt_count), DW'(0));
            chk("post_rst_err_count", DW'(err_count), DW'(0));
        end
        send_pkt(16'h0010, 1, '1);
        drain();
        chk("post_rst_pkt_done", DW'(pkt_count), DW'(1));
        chk("post_rst_err_done", DW'(err_count), DW'(0));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
